// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for one radix-2 single-delay-feedback FFT stage.
// Tracks the beat position inside a frame, generates the delay-line shift
// enable, butterfly/bypass select and twiddle base, and drains the delay
// line for DCYC cycles after every frame. All sequencing outputs are
// combinational from registered state plus the current input handshake,
// so they line up with the data vector presented in the same cycle.
module fft_sdf_stage_ctrl #(
  parameter int LANES     = 16,
  parameter int MEM_DEPTH = 256,
  parameter int FRAME_LEN = 512,
  localparam int TW_W     = $clog2(MEM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_sof,
  output logic            in_ready,
  output logic            sr_shift,
  output logic            bf_sel,
  output logic [TW_W-1:0] tw_base,
  output logic            out_valid,
  output logic            out_sof,
  output logic            out_eof,
  output logic            busy,
  output logic            err_sof
);

  localparam int DCYC  = MEM_DEPTH / LANES;
  localparam int FCYC  = FRAME_LEN / LANES;
  localparam int CNT_W = (FCYC > 1) ? $clog2(FCYC) : 1;
  localparam int PH_W  = $clog2(2 * DCYC);
  localparam int FL_W  = (DCYC > 1) ? $clog2(DCYC) : 1;

  localparam logic [CNT_W-1:0] DCYC_CNT  = CNT_W'(DCYC);
  localparam logic [CNT_W-1:0] FCYC_LAST = CNT_W'(FCYC - 1);
  localparam logic [PH_W-1:0]  DCYC_PH   = PH_W'(DCYC);
  localparam logic [FL_W-1:0]  FL_LAST   = FL_W'(DCYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic             err_sof_q, err_sof_d;

  // Working values for the beat currently on the input.
  logic             accept;
  logic             beat_act;
  logic [CNT_W-1:0] eff_cnt;
  logic [PH_W-1:0]  ph;
  logic [PH_W-1:0]  tw_off;

  // Output decode and next-state computation; reset forces every output low.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    err_sof_d   = err_sof_q;

    in_ready  = 1'b0;
    sr_shift  = 1'b0;
    bf_sel    = 1'b0;
    tw_base   = '0;
    out_valid = 1'b0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    busy      = 1'b0;
    err_sof   = 1'b0;

    accept   = 1'b0;
    beat_act = 1'b0;
    eff_cnt  = beat_cnt_q;
    ph       = '0;
    tw_off   = '0;

    if (!rst) begin
      busy    = (state_q != S_IDLE);
      err_sof = err_sof_q;

      case (state_q)
        S_IDLE: begin
          in_ready = 1'b1;
          accept   = in_valid;
          // Only a start-of-frame beat opens a frame; anything else is dropped.
          if (accept && in_sof) begin
            beat_act = 1'b1;
            eff_cnt  = '0;
          end
        end
        S_RUN: begin
          in_ready = 1'b1;
          accept   = in_valid;
          if (accept) begin
            beat_act = 1'b1;
            if (in_sof) begin
              // A new sof restarts the frame; mid-frame it is also flagged.
              eff_cnt = '0;
              if (beat_cnt_q != '0) begin
                err_sof_d = 1'b1;
              end
            end
          end
        end
        S_FLUSH: begin
          sr_shift  = 1'b1;
          out_valid = 1'b1;
          out_eof   = (flush_cnt_q == FL_LAST);
          if (flush_cnt_q == FL_LAST) begin
            flush_cnt_d = '0;
            state_d     = S_IDLE;
          end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (beat_act) begin
        ph        = eff_cnt[PH_W-1:0];
        sr_shift  = 1'b1;
        bf_sel    = (ph >= DCYC_PH);
        tw_off    = ph - DCYC_PH;
        tw_base   = bf_sel ? (TW_W'(tw_off) * TW_W'(LANES)) : '0;
        out_valid = (eff_cnt >= DCYC_CNT);
        out_sof   = (eff_cnt == DCYC_CNT);
        if (eff_cnt == FCYC_LAST) begin
          beat_cnt_d  = '0;
          flush_cnt_d = '0;
          state_d     = S_FLUSH;
        end else begin
          beat_cnt_d = eff_cnt + 1'b1;
          state_d    = S_RUN;
        end
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      err_sof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_sof_q   <= err_sof_d;
    end
  end

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Directed bench for fft_sdf_stage_ctrl with default parameters
// (DCYC = 16, FCYC = 32, tw_base 8 bits). Inputs change just after the
// falling edge and outputs are sampled 1 ns later, well clear of posedge.
module tb_fft_sdf_stage_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic       in_ready;
  logic       sr_shift;
  logic       bf_sel;
  logic [7:0] tw_base;
  logic       out_valid;
  logic       out_sof;
  logic       out_eof;
  logic       busy;
  logic       err_sof;

  // Snapshot of the outputs for the most recent cycle.
  logic       s_ready, s_sr, s_bf, s_ov, s_sof, s_eof, s_busy, s_err;
  logic [7:0] s_tw;

  int n_chk  = 0;
  int n_pass = 0;

  fft_sdf_stage_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .sr_shift  (sr_shift),
    .bf_sel    (bf_sel),
    .tw_base   (tw_base),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .busy      (busy),
    .err_sof   (err_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive one cycle of input, snapshot outputs, advance to the next negedge.
  task automatic cyc(input logic v, input logic s);
    in_valid = v;
    in_sof   = s;
    #1;
    s_ready = in_ready;  s_sr  = sr_shift; s_bf   = bf_sel;  s_tw  = tw_base;
    s_ov    = out_valid; s_sof = out_sof;  s_eof  = out_eof; s_busy = busy;
    s_err   = err_sof;
    @(negedge clk);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({s_ready, s_sr, s_bf, s_tw, s_ov, s_sof, s_eof, s_busy, s_err});
  endfunction

  // One continuous frame from IDLE, checked beat by beat, plus its flush.
  task automatic nominal_frame(input string tag);
    int sr_run;
    int ov_cnt;
    sr_run = 0;
    ov_cnt = 0;
    for (int b = 0; b < 32; b++) begin
      cyc(1'b1, b == 0);
      check($sformatf("%s b%0d ready", tag, b), 32'(s_ready), 1);
      check($sformatf("%s b%0d sr", tag, b), 32'(s_sr), 1);
      check($sformatf("%s b%0d bf", tag, b), 32'(s_bf), (b >= 16) ? 1 : 0);
      check($sformatf("%s b%0d tw", tag, b), 32'(s_tw), (b >= 16) ? (b - 16) * 16 : 0);
      check($sformatf("%s b%0d ov", tag, b), 32'(s_ov), (b >= 16) ? 1 : 0);
      check($sformatf("%s b%0d osof", tag, b), 32'(s_sof), (b == 16) ? 1 : 0);
      check($sformatf("%s b%0d eof", tag, b), 32'(s_eof), 0);
      check($sformatf("%s b%0d busy", tag, b), 32'(s_busy), (b != 0) ? 1 : 0);
      if (s_sr) sr_run++;
      if (s_ov) ov_cnt++;
    end
    for (int f = 0; f < 16; f++) begin
      cyc(1'b0, 1'b0);
      check($sformatf("%s f%0d ready", tag, f), 32'(s_ready), 0);
      check($sformatf("%s f%0d sr", tag, f), 32'(s_sr), 1);
      check($sformatf("%s f%0d bf", tag, f), 32'(s_bf), 0);
      check($sformatf("%s f%0d ov", tag, f), 32'(s_ov), 1);
      check($sformatf("%s f%0d eof", tag, f), 32'(s_eof), (f == 15) ? 1 : 0);
      check($sformatf("%s f%0d busy", tag, f), 32'(s_busy), 1);
      if (s_sr) sr_run++;
      if (s_ov) ov_cnt++;
    end
    cyc(1'b0, 1'b0);
    check({tag, " post busy"}, 32'(s_busy), 0);
    check({tag, " post sr"}, 32'(s_sr), 0);
    check({tag, " post ready"}, 32'(s_ready), 1);
    check({tag, " sr run"}, 32'(sr_run), 48);
    check({tag, " ov total"}, 32'(ov_cnt), 32);
    $display("%s: frame done, sr_shift cycles=%0d out_valid beats=%0d", tag, sr_run, ov_cnt);
  endtask

  initial begin
    int first_bf;
    int ov_cnt;
    int sof_k;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    @(negedge clk);

    // Reset dominates even an offered sof.
    cyc(1'b1, 1'b1);
    check("reset outs", all_outs(), 0);
    cyc(1'b1, 1'b1);
    check("reset outs 2", all_outs(), 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0);
    check("idle ready", 32'(s_ready), 1);
    check("idle busy", 32'(s_busy), 0);

    // Scenario 1: continuous frame.
    nominal_frame("frame1");

    // Scenario 2: 3-cycle stall after beat 10.
    first_bf = -1;
    ov_cnt   = 0;
    for (int c = 0; c < 35; c++) begin
      logic v;
      v = !(c >= 11 && c <= 13);
      cyc(v, c == 0);
      if (!v) begin
        check($sformatf("stall c%0d sr", c), 32'(s_sr), 0);
        check($sformatf("stall c%0d ov", c), 32'(s_ov), 0);
      end
      if (s_bf && first_bf < 0) first_bf = c;
      if (s_ov) ov_cnt++;
    end
    for (int f = 0; f < 16; f++) begin
      cyc(1'b0, 1'b0);
      if (s_ov) ov_cnt++;
      if (f == 15) check("stall eof", 32'(s_eof), 1);
    end
    cyc(1'b0, 1'b0);
    check("stall first bf cycle", 32'(first_bf), 19);
    check("stall ov total", 32'(ov_cnt), 32);
    check("stall post busy", 32'(s_busy), 0);
    $display("stall: first bf_sel at cycle %0d, out_valid beats=%0d", first_bf, ov_cnt);

    // Scenario 3: sof re-asserted with beat_cnt = 20.
    for (int b = 0; b < 20; b++) cyc(1'b1, b == 0);
    cyc(1'b1, 1'b1);
    check("resof sr", 32'(s_sr), 1);
    check("resof bf", 32'(s_bf), 0);
    check("resof ov", 32'(s_ov), 0);
    check("resof err same cycle", 32'(s_err), 0);
    sof_k  = -1;
    ov_cnt = 0;
    for (int k = 1; k < 32; k++) begin
      cyc(1'b1, 1'b0);
      if (k == 1) begin
        check("resof err next", 32'(s_err), 1);
        check("resof k1 ov", 32'(s_ov), 0);
      end
      if (k == 16) check("resof k16 tw", 32'(s_tw), 0);
      if (k == 17) check("resof k17 tw", 32'(s_tw), 16);
      if (s_sof && sof_k < 0) sof_k = k;
      if (s_ov) ov_cnt++;
    end
    for (int f = 0; f < 16; f++) begin
      cyc(1'b0, 1'b0);
      if (s_ov) ov_cnt++;
    end
    cyc(1'b0, 1'b0);
    check("resof out_sof offset", 32'(sof_k), 16);
    check("resof ov total", 32'(ov_cnt), 32);
    check("resof err sticky", 32'(s_err), 1);
    check("resof post busy", 32'(s_busy), 0);
    $display("resof: out_sof %0d beats after re-sof, err_sof=%0d", sof_k, s_err);

    // Clear the sticky error.
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;

    // Scenario 4: non-sof beats in IDLE are discarded.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0);
      check($sformatf("junk%0d sr", i), 32'(s_sr), 0);
      check($sformatf("junk%0d ov", i), 32'(s_ov), 0);
      check($sformatf("junk%0d busy", i), 32'(s_busy), 0);
      check($sformatf("junk%0d err", i), 32'(s_err), 0);
      check($sformatf("junk%0d ready", i), 32'(s_ready), 1);
    end
    $display("idle junk: 5 beats discarded");

    // Scenario 5: next sof held off during FLUSH, then reset on beat 25.
    for (int b = 0; b < 32; b++) cyc(1'b1, b == 0);
    for (int f = 0; f < 16; f++) begin
      cyc(1'b1, 1'b1);
      check($sformatf("b2b f%0d ready", f), 32'(s_ready), 0);
      check($sformatf("b2b f%0d sr", f), 32'(s_sr), 1);
      if (f == 15) check("b2b eof", 32'(s_eof), 1);
    end
    cyc(1'b1, 1'b1);
    check("b2b accept ready", 32'(s_ready), 1);
    check("b2b accept sr", 32'(s_sr), 1);
    check("b2b accept bf", 32'(s_bf), 0);
    check("b2b accept ov", 32'(s_ov), 0);
    check("b2b accept busy", 32'(s_busy), 0);
    for (int b = 1; b < 25; b++) begin
      cyc(1'b1, 1'b0);
      if (b == 24) begin
        check("b2b b24 bf", 32'(s_bf), 1);
        check("b2b b24 tw", 32'(s_tw), 128);
        check("b2b b24 ov", 32'(s_ov), 1);
      end
    end
    rst = 1'b1;
    cyc(1'b1, 1'b0);
    check("midrun reset outs", all_outs(), 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0);
    check("after reset busy", 32'(s_busy), 0);
    check("after reset sr", 32'(s_sr), 0);
    check("after reset ov", 32'(s_ov), 0);
    check("after reset ready", 32'(s_ready), 1);
    check("after reset err", 32'(s_err), 0);
    $display("b2b: sof accepted after flush, reset on beat 25 aborted without flush");

    nominal_frame("frame_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
